// File: rtl/ff_flags_mon.sv
// FIFO flag monitor: sticky overflow/underflow bits, saturating event counters and clear pulses per interface.
// Define FF_FLAGS_MON_IRQ_EN to build the IRQ_MASK register and the irq output.
module ff_flags_mon #(
  parameter int NUM_INTFS = 4,
  parameter int CNTR_W    = 8,
  parameter int LB_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_INTFS-1:0] ff_ovrflw,
  input  logic [NUM_INTFS-1:0] ff_undrflw,
  output logic [NUM_INTFS-1:0] clear_flags,
  input  logic                 lb_wr_en,
  input  logic                 lb_rd_en,
  input  logic [LB_ADDR_W-1:0] lb_addr,
  input  logic [31:0]          lb_wr_data,
  output logic                 lb_rd_valid,
  output logic [31:0]          lb_rd_data,
  output logic                 irq
);

  localparam logic [LB_ADDR_W-1:0] ADDR_STATUS   = LB_ADDR_W'(0);
  localparam logic [LB_ADDR_W-1:0] ADDR_CLEAR    = LB_ADDR_W'(1);
  localparam logic [LB_ADDR_W-1:0] ADDR_IRQ_MASK = LB_ADDR_W'(2);
  localparam int                   ADDR_CNT_BASE = 16;
  localparam logic [31:0] INTF_BITS   = 32'((64'd1 << NUM_INTFS) - 64'd1);
  localparam logic [31:0] STATUS_BITS = INTF_BITS | (INTF_BITS << 16);

  logic [NUM_INTFS-1:0] ovr_sticky, und_sticky;
  logic [CNTR_W-1:0]    ovr_cnt [NUM_INTFS];
  logic [CNTR_W-1:0]    und_cnt [NUM_INTFS];
  logic [NUM_INTFS-1:0] clr_vec;
  logic [31:0]          status_word, mask_word, rd_word;
  logic                 unused_wr_bits;

  assign unused_wr_bits = &{1'b0, lb_wr_data};

  // A clear zeroes the counter first, then a same-cycle event still counts once.
  function automatic logic [CNTR_W-1:0] next_cnt(input logic [CNTR_W-1:0] cnt,
                                                 input logic clr, input logic flag);
    logic [CNTR_W-1:0] base;
    base = clr ? '0 : cnt;
    if (flag && (base != '1)) return base + CNTR_W'(1);
    return base;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    clr_vec = '0;
    if (lb_wr_en && (lb_addr == ADDR_CLEAR)) clr_vec = lb_wr_data[NUM_INTFS-1:0];
  end

  always_comb begin
    status_word                 = '0;
    status_word[NUM_INTFS-1:0]  = ovr_sticky;
    status_word[16 +: NUM_INTFS] = und_sticky;
  end

  always_comb begin
    rd_word = '0;
    if (lb_addr == ADDR_STATUS)   rd_word = status_word;
    if (lb_addr == ADDR_IRQ_MASK) rd_word = mask_word;
    for (int i = 0; i < NUM_INTFS; i++) begin
      if (lb_addr == LB_ADDR_W'(ADDR_CNT_BASE + i)) begin
        rd_word[CNTR_W-1:0]   = ovr_cnt[i];
        rd_word[16 +: CNTR_W] = und_cnt[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_sticky <= '0;
      und_sticky <= '0;
      // NOTE: the counters are flops, not a RAM, so clearing them all on reset is cheap and required.
      for (int i = 0; i < NUM_INTFS; i++) begin
        ovr_cnt[i] <= '0;
        und_cnt[i] <= '0;
      end
    end else begin
      ovr_sticky <= (ovr_sticky & ~clr_vec) | ff_ovrflw;
      und_sticky <= (und_sticky & ~clr_vec) | ff_undrflw;
      for (int i = 0; i < NUM_INTFS; i++) begin
        ovr_cnt[i] <= next_cnt(ovr_cnt[i], clr_vec[i], ff_ovrflw[i]);
        und_cnt[i] <= next_cnt(und_cnt[i], clr_vec[i], ff_undrflw[i]);
      end
    end
  end

  // Read data is captured from pre-write state, so a simultaneous write is not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_rd_valid <= 1'b0;
      lb_rd_data  <= '0;
      clear_flags <= '0;
    end else begin
      lb_rd_valid <= lb_rd_en;
      if (lb_rd_en) lb_rd_data <= rd_word;
      clear_flags <= clr_vec;
    end
  end

`ifdef FF_FLAGS_MON_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_word <= '0;
      irq       <= 1'b0;
    end else begin
      if (lb_wr_en && (lb_addr == ADDR_IRQ_MASK)) mask_word <= lb_wr_data & STATUS_BITS;
      irq <= |(status_word & mask_word);
    end
  end
`else
  assign mask_word = '0;
  assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_ff_flags_mon.sv
// Self-checking bench for ff_flags_mon: cycle model of the register map plus directed literal checks.
module tb_ff_flags_mon;
  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int AW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  ff_ovrflw = '0, ff_undrflw = '0;
  logic [N-1:0]  clear_flags;
  logic          lb_wr_en = 1'b0, lb_rd_en = 1'b0;
  logic [AW-1:0] lb_addr = '0;
  logic [31:0]   lb_wr_data = '0;
  logic          lb_rd_valid;
  logic [31:0]   lb_rd_data;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  ff_flags_mon #(.NUM_INTFS(N), .CNTR_W(CW), .LB_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ff_ovrflw(ff_ovrflw), .ff_undrflw(ff_undrflw), .clear_flags(clear_flags),
    .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr),
    .lb_wr_data(lb_wr_data), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer counters with min(), sticky flags as bits, register map by address.
  int          m_ovr_cnt[N], m_und_cnt[N];
  bit          m_ovr_st[N], m_und_st[N];
  logic [31:0] m_mask = '0;
  logic [N-1:0] e_clear = '0;
  logic        e_valid = 1'b0, e_irq = 1'b0;
  logic [31:0] e_data = '0;
  bit          armed = 1'b0;

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    logic [31:0] r;
    int idx;
    r = '0;
    idx = int'(a);
    if (idx == 0) begin
      for (int i = 0; i < N; i++) begin
        r[i]      = m_ovr_st[i];
        r[16 + i] = m_und_st[i];
      end
    end else if (idx == 2) begin
      r = m_mask;
    end else if (idx >= 16 && idx < 16 + N) begin
      r = 32'(m_ovr_cnt[idx-16]) + (32'(m_und_cnt[idx-16]) << 16);
    end
    return r;
  endfunction

  initial forever begin
    logic [N-1:0] clr;
    logic [31:0]  st;
    @(posedge clk);
    if (rst) begin
      armed = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_ovr_cnt[i] = 0; m_und_cnt[i] = 0; m_ovr_st[i] = 0; m_und_st[i] = 0;
      end
      m_mask = '0; e_clear = '0; e_valid = 1'b0; e_irq = 1'b0; e_data = '0;
    end else begin
      st = model_read(AW'(0));
      e_valid = lb_rd_en;
      if (lb_rd_en) e_data = model_read(lb_addr);
`ifdef FF_FLAGS_MON_IRQ_EN
      e_irq = |(st & m_mask);
      if (lb_wr_en && lb_addr == AW'(2)) m_mask = lb_wr_data & 32'h000F_000F;
`else
      e_irq = 1'b0;
`endif
      clr = (lb_wr_en && lb_addr == AW'(1)) ? lb_wr_data[N-1:0] : '0;
      e_clear = clr;
      for (int i = 0; i < N; i++) begin
        if (clr[i]) begin
          m_ovr_cnt[i] = 0; m_und_cnt[i] = 0; m_ovr_st[i] = 0; m_und_st[i] = 0;
        end
        if (ff_ovrflw[i]) begin
          m_ovr_st[i] = 1;
          if (m_ovr_cnt[i] < CMAX) m_ovr_cnt[i]++;
        end
        if (ff_undrflw[i]) begin
          m_und_st[i] = 1;
          if (m_und_cnt[i] < CMAX) m_und_cnt[i]++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      check("cyc_clear_flags", 32'(clear_flags), 32'(e_clear));
      check("cyc_irq",         32'(irq),         32'(e_irq));
      check("cyc_rd_valid",    32'(lb_rd_valid), 32'(e_valid));
      check("cyc_rd_data",     lb_rd_data,       e_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
    lb_rd_en = 1'b1; lb_addr = a;
    tick();
    lb_rd_en = 1'b0;
    check({name, "_valid"}, 32'(lb_rd_valid), 32'd1);
    check(name, lb_rd_data, exp);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    lb_wr_en = 1'b1; lb_addr = a; lb_wr_data = d;
    tick();
    lb_wr_en = 1'b0; lb_wr_data = '0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    ff_ovrflw = 4'b1000; tick(); ff_ovrflw = '0;

    // Reset lands on a read in flight: no valid may come out of it.
    lb_rd_en = 1'b1; lb_addr = 8'h00; rst = 1'b1;
    tick();
    lb_rd_en = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_rd_valid", 32'(lb_rd_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_clear_flags", 32'(clear_flags), 32'd0);
    check("rst_rd_data", lb_rd_data, 32'd0);
    rd(8'h00, 32'h0, "rst_status");
    for (int i = 0; i < N; i++) rd(AW'(16 + i), 32'h0, "rst_count");

    // Counting
    ff_ovrflw = 4'b0010; ff_undrflw = 4'b0100; tick();
    ff_undrflw = '0; tick(); tick();
    ff_ovrflw = '0;
    rd(8'h00, 32'h0004_0002, "cnt_status");
    rd(8'h11, 32'h0000_0003, "cnt_count1");
    rd(8'h12, 32'h0001_0000, "cnt_count2");

    // Clear of interface 1, then clear racing a new event
    wr(8'h01, 32'h2);
    check("clr_pulse_n1", 32'(clear_flags), 32'h2);
    tick();
    check("clr_pulse_n2", 32'(clear_flags), 32'h0);
    rd(8'h00, 32'h0004_0000, "clr_status");
    rd(8'h11, 32'h0, "clr_count1");
    ff_ovrflw = 4'b0010; wr(8'h01, 32'h2); ff_ovrflw = '0;
    check("clr_race_pulse", 32'(clear_flags), 32'h2);
    rd(8'h11, 32'h1, "clr_race_count1");
    rd(8'h00, 32'h0004_0002, "clr_race_status");
    wr(8'h01, 32'h0);
    check("clr_empty_nopulse", 32'(clear_flags), 32'h0);

    // Saturation
    ff_ovrflw = 4'b0001;
    repeat (300) tick();
    ff_ovrflw = '0;
    rd(8'h10, 32'h0000_00FF, "sat_count0");
    rd(8'h00, 32'h0004_0003, "sat_status");

    // Simultaneous read and write of CLEAR: the write executes, read returns 0
    lb_rd_en = 1'b1; lb_wr_en = 1'b1; lb_addr = 8'h01; lb_wr_data = 32'h4;
    tick();
    lb_rd_en = 1'b0; lb_wr_en = 1'b0; lb_wr_data = '0;
    check("rdwr_clear_data", lb_rd_data, 32'h0);
    check("rdwr_clear_pulse", 32'(clear_flags), 32'h4);
    rd(8'h00, 32'h0000_0003, "rdwr_status");

`ifdef FF_FLAGS_MON_IRQ_EN
    lb_rd_en = 1'b1; lb_wr_en = 1'b1; lb_addr = 8'h02; lb_wr_data = 32'h0001_0000;
    tick();
    lb_rd_en = 1'b0; lb_wr_en = 1'b0; lb_wr_data = '0;
    check("irq_mask_prewrite", lb_rd_data, 32'h0);
    rd(8'h02, 32'h0001_0000, "irq_mask_read");
    check("irq_idle", 32'(irq), 32'd0);
    ff_undrflw = 4'b0001; tick(); ff_undrflw = '0;
    check("irq_sticky_cycle", 32'(irq), 32'd0);
    tick();
    check("irq_rise", 32'(irq), 32'd1);
    wr(8'h01, 32'h1);
    check("irq_clear_n1", 32'(irq), 32'd1);
    tick();
    check("irq_clear_n2", 32'(irq), 32'd0);
    ff_ovrflw = 4'b1000; tick(); ff_ovrflw = '0;
    tick(); tick();
    check("irq_masked_ovr3", 32'(irq), 32'd0);
`else
    wr(8'h02, 32'h0001_0000);
    rd(8'h02, 32'h0, "irq_mask_absent");
    ff_undrflw = 4'b0001; tick(); ff_undrflw = '0;
    tick(); tick();
    check("irq_tied_low", 32'(irq), 32'd0);
    ff_ovrflw = 4'b1000; tick(); ff_ovrflw = '0;
    tick();
`endif

    // Bus: unmapped read, then back-to-back reads
    rd(8'h7F, 32'h0, "bus_unmapped");
    lb_rd_en = 1'b1; lb_addr = 8'h00;
    tick();
    lb_addr = 8'h10;
    check("b2b_valid0", 32'(lb_rd_valid), 32'd1);
`ifdef FF_FLAGS_MON_IRQ_EN
    check("b2b_status", lb_rd_data, 32'h0000_000A);
`else
    check("b2b_status", lb_rd_data, 32'h0001_000B);
`endif
    tick();
    lb_rd_en = 1'b0;
    check("b2b_valid1", 32'(lb_rd_valid), 32'd1);
`ifdef FF_FLAGS_MON_IRQ_EN
    check("b2b_count0", lb_rd_data, 32'h0000_0000);
`else
    check("b2b_count0", lb_rd_data, 32'h0001_00FF);
`endif
    tick();
    check("b2b_valid_end", 32'(lb_rd_valid), 32'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
